// File: rtl/tdm_demux4.sv
// Four-channel TDM receive demultiplexer: aligns on a slot-0 frame marker, collects
// four beats and presents each complete frame as registered parallel words.
module tdm_demux4 #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] din,
  input  logic         din_valid,
  input  logic         fsync,
  output logic [W-1:0] ch0,
  output logic [W-1:0] ch1,
  output logic [W-1:0] ch2,
  output logic [W-1:0] ch3,
  output logic         frame_valid,
  output logic         locked,
  output logic [1:0]   slot,
  output logic         err
);

  typedef enum logic {HUNT, LOCKED} state_t;

  state_t       state_q, state_d;
  logic [1:0]   slot_q, slot_d;
  logic [W-1:0] sh_q [3];
  logic [W-1:0] sh_d [3];
  logic [W-1:0] ch_q [4];
  logic [W-1:0] ch_d [4];
  logic         fv_q, fv_d;
  logic         err_q, err_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= HUNT;
      slot_q  <= '0;
      fv_q    <= 1'b0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < 3; i++) sh_q[i] <= '0;
      for (int unsigned i = 0; i < 4; i++) ch_q[i] <= '0;
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      fv_q    <= fv_d;
      err_q   <= err_d;
      sh_q    <= sh_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    sh_d    = sh_q;
    ch_d    = ch_q;
    fv_d    = 1'b0;
    err_d   = 1'b0;
    if (din_valid) begin
      unique case (state_q)
        HUNT: begin
          if (fsync) begin
            sh_d[0] = din;
            slot_d  = 2'd1;
            state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (fsync) begin
            // An early marker abandons the partial frame and restarts at slot 0.
            err_d   = (slot_q != 2'd0);
            sh_d[0] = din;
            slot_d  = 2'd1;
          end else if (slot_q == 2'd0) begin
            err_d   = 1'b1;
            slot_d  = 2'd0;
            state_d = HUNT;
          end else if (slot_q == 2'd3) begin
            ch_d[0] = sh_q[0];
            ch_d[1] = sh_q[1];
            ch_d[2] = sh_q[2];
            ch_d[3] = din;
            fv_d    = 1'b1;
            slot_d  = 2'd0;
          end else begin
            sh_d[slot_q] = din;
            slot_d       = slot_q + 2'd1;
          end
        end
        default: state_d = HUNT;
      endcase
    end
  end

  always_comb begin
    ch0         = ch_q[0];
    ch1         = ch_q[1];
    ch2         = ch_q[2];
    ch3         = ch_q[3];
    frame_valid = fv_q;
    err         = err_q;
    locked      = (state_q == LOCKED);
    slot        = slot_q;
  end

endmodule

// File: tb/tb_tdm_demux4.sv
// Bench for tdm_demux4: directed frame scenarios followed by random beats, checked
// against a queue-based model of frame assembly.
module tb_tdm_demux4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [7:0] din = '0;
  logic       din_valid = 1'b0;
  logic       fsync = 1'b0;
  logic [7:0] ch0, ch1, ch2, ch3;
  logic       frame_valid, locked, err;
  logic [1:0] slot;

  int total = 0;
  int bad   = 0;

  bit         mlock = 0;
  logic [7:0] part[$];
  logic [7:0] ech[4] = '{default: 8'h00};
  logic       efv = 1'b0;
  logic       eerr = 1'b0;

  tdm_demux4 #(.W(8)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .fsync(fsync),
    .ch0(ch0), .ch1(ch1), .ch2(ch2), .ch3(ch3),
    .frame_valid(frame_valid), .locked(locked), .slot(slot), .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    chk("ch0", 32'(ch0), 32'(ech[0]));
    chk("ch1", 32'(ch1), 32'(ech[1]));
    chk("ch2", 32'(ch2), 32'(ech[2]));
    chk("ch3", 32'(ch3), 32'(ech[3]));
    chk("frame_valid", 32'(frame_valid), 32'(efv));
    chk("err", 32'(err), 32'(eerr));
    chk("locked", 32'(locked), 32'(mlock));
    chk("slot", 32'(slot), mlock ? 32'(part.size()) : 32'd0);
  endtask

  // The partial frame lives in a queue; its length is the next slot index.
  task automatic model(input logic v, input logic fs, input logic [7:0] d);
    efv  = 1'b0;
    eerr = 1'b0;
    if (!v) return;
    if (!mlock) begin
      if (fs) begin
        part.delete();
        part.push_back(d);
        mlock = 1;
      end
    end else if (fs) begin
      eerr = (part.size() != 0);
      part.delete();
      part.push_back(d);
    end else if (part.size() == 0) begin
      eerr  = 1'b1;
      mlock = 0;
    end else begin
      part.push_back(d);
      if (part.size() == 4) begin
        for (int i = 0; i < 4; i++) ech[i] = part[i];
        efv = 1'b1;
        part.delete();
      end
    end
  endtask

  task automatic step(input logic v, input logic fs, input logic [7:0] d);
    din_valid = v;
    fsync     = fs;
    din       = d;
    @(posedge clk);
    #1;
    model(v, fs, d);
    check_all();
  endtask

  task automatic model_reset();
    mlock = 0;
    part.delete();
    for (int i = 0; i < 4; i++) ech[i] = 8'h00;
    efv  = 1'b0;
    eerr = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all();
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  initial begin
    do_reset();

    // Two contiguous frames
    for (int i = 0; i < 8; i++)
      step(1'b1, (i == 0 || i == 4), 8'((i + 1) * 8'h11));

    // Hunt discards unmarked beats, then locks
    do_reset();
    step(1'b1, 1'b0, 8'h5A);
    step(1'b1, 1'b0, 8'h5B);
    step(1'b1, 1'b0, 8'h5C);
    for (int i = 0; i < 4; i++) step(1'b1, (i == 0), 8'hA0 + 8'(i));

    // Stalled frame with a marker pulsed during the gap
    step(1'b1, 1'b1, 8'hA0);
    step(1'b1, 1'b0, 8'hA1);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'($urandom));
    step(1'b1, 1'b0, 8'hA2);
    step(1'b1, 1'b0, 8'hA3);

    // Early sync
    step(1'b1, 1'b1, 8'h00);
    step(1'b1, 1'b0, 8'h01);
    step(1'b1, 1'b0, 8'h02);
    step(1'b1, 1'b1, 8'h10);
    step(1'b1, 1'b0, 8'h11);
    step(1'b1, 1'b0, 8'h12);
    step(1'b1, 1'b0, 8'h13);

    // Missing sync at slot 0, then relock
    step(1'b1, 1'b0, 8'h99);
    for (int i = 0; i < 4; i++) step(1'b1, (i == 0), 8'hC0 + 8'(i));

    // Reset mid-frame
    step(1'b1, 1'b1, 8'hD0);
    step(1'b1, 1'b0, 8'hD1);
    do_reset();
    step(1'b1, 1'b0, 8'hD2);
    step(1'b1, 1'b0, 8'hD3);

    // Random traffic, markers biased toward frame boundaries
    for (int n = 0; n < 400; n++) begin
      logic v, fs;
      v  = ($urandom_range(0, 9) < 8);
      fs = (part.size() == 0) ? ($urandom_range(0, 9) < 8) : ($urandom_range(0, 19) == 0);
      if (n % 137 == 136) do_reset();
      step(v, fs, 8'($urandom));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
